// File: rtl/load_store_peak_monitor.sv
// load_store_peak_monitor
//
// Watches the peak strobe from the load/store ramp stage. It counts peak rising edges, measures
// the rise-to-rise period and checks it against a tolerance window. Each result goes to the
// status/log stage over a valid/ready interface.
//
// Ports:
//   clk         clock, all logic on posedge
//   rst         synchronous reset, active-high
//   sig_in      peak strobe (same clock domain)
//   out_valid   period result available
//   out_ready   consumer accepts result when out_valid && out_ready
//   out_period  measured rise-to-rise period in cycles
//   out_err     measured period lies outside [EXP_PERIOD-TOL, EXP_PERIOD+TOL]
//   peak_count  rising edges seen since reset (wraps)
//   timeout     sticky: period counter saturated without a peak
//   overflow    sticky: a result was dropped because the output was still busy
module load_store_peak_monitor #(
   parameter int unsigned PBITS      = 16,
   parameter int unsigned EXP_PERIOD = 40002,
   parameter int unsigned TOL        = 4,
   parameter int unsigned CNTBITS    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sig_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PBITS-1:0]   out_period,
   output logic               out_err,
   output logic [CNTBITS-1:0] peak_count,
   output logic               timeout,
   output logic               overflow
);

   // Window bounds carry one extra bit so EXP_PERIOD+TOL cannot wrap; the low bound clamps at 0.
   localparam logic [PBITS:0] WinLo =
      (EXP_PERIOD > TOL) ? (PBITS+1)'(EXP_PERIOD - TOL) : '0;
   localparam logic [PBITS:0] WinHi = (PBITS+1)'(EXP_PERIOD + TOL);

   typedef enum logic {
      StIdle,
      StMeas
   } state_e;

   state_e               state_q, state_d;
   logic                 sig_d_q, sig_d_d;
   logic [PBITS-1:0]     cnt_q, cnt_d;
   logic                 out_valid_q, out_valid_d;
   logic [PBITS-1:0]     out_period_q, out_period_d;
   logic                 out_err_q, out_err_d;
   logic [CNTBITS-1:0]   peak_count_q, peak_count_d;
   logic                 timeout_q, timeout_d;
   logic                 overflow_q, overflow_d;

   logic                 rise;
   logic                 produce;
   logic                 accept;
   logic [PBITS:0]       p_ext;
   logic                 period_bad;

   always_comb begin
      state_d      = state_q;
      sig_d_d      = sig_in;
      cnt_d        = cnt_q;
      out_valid_d  = out_valid_q;
      out_period_d = out_period_q;
      out_err_d    = out_err_q;
      peak_count_d = peak_count_q;
      timeout_d    = timeout_q;
      overflow_d   = overflow_q;
      produce      = 1'b0;

      rise   = sig_in & ~sig_d_q;
      accept = out_valid_q & out_ready;

      // The counter value at the rise edge is the number of cycles since the previous rise.
      p_ext      = {1'b0, cnt_q};
      period_bad = (p_ext < WinLo) || (p_ext > WinHi);

      if (rise) begin
         peak_count_d = peak_count_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (rise) begin
               state_d = StMeas;
               cnt_d   = PBITS'(1);
            end
         end
         StMeas: begin
            if (rise) begin
               produce = 1'b1;
               cnt_d   = PBITS'(1);
            end else if (cnt_q == '1) begin
               // Peak lost: give up on this measurement; the next rise only restarts timing.
               timeout_d = 1'b1;
               state_d   = StIdle;
               cnt_d     = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase

      if (produce) begin
         // A slot frees up when the current result is being accepted this same cycle.
         if (!out_valid_q || out_ready) begin
            out_valid_d  = 1'b1;
            out_period_d = cnt_q;
            out_err_d    = period_bad;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (accept) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         sig_d_q      <= 1'b0;
         cnt_q        <= '0;
         out_valid_q  <= 1'b0;
         out_period_q <= '0;
         out_err_q    <= 1'b0;
         peak_count_q <= '0;
         timeout_q    <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         sig_d_q      <= sig_d_d;
         cnt_q        <= cnt_d;
         out_valid_q  <= out_valid_d;
         out_period_q <= out_period_d;
         out_err_q    <= out_err_d;
         peak_count_q <= peak_count_d;
         timeout_q    <= timeout_d;
         overflow_q   <= overflow_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_period = out_period_q;
   assign out_err    = out_err_q;
   assign peak_count = peak_count_q;
   assign timeout    = timeout_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_load_store_peak_monitor.sv
// Bench for load_store_peak_monitor (PBITS=6, EXP_PERIOD=10, TOL=1, CNTBITS=4).
// The reference model works on absolute cycle numbers of rising edges: a period is the
// difference between two rise cycles, and a timeout is 63 cycles elapsing since the last rise.
module tb_load_store_peak_monitor;

   localparam int unsigned PB   = 6;
   localparam int unsigned EXP  = 10;
   localparam int unsigned TOL  = 1;
   localparam int unsigned CB   = 4;
   localparam int          MAXC = (1 << PB) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          sig_in;
   logic          out_ready;
   logic          out_valid;
   logic [PB-1:0] out_period;
   logic          out_err;
   logic [CB-1:0] peak_count;
   logic          timeout;
   logic          overflow;

   always #5 clk = ~clk;

   load_store_peak_monitor #(
      .PBITS      (PB),
      .EXP_PERIOD (EXP),
      .TOL        (TOL),
      .CNTBITS    (CB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_period (out_period),
      .out_err    (out_err),
      .peak_count (peak_count),
      .timeout    (timeout),
      .overflow   (overflow)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int m_cyc    = 0;
   int m_last   = 0;
   bit m_prev   = 1'b0;
   bit m_meas   = 1'b0;
   bit m_valid  = 1'b0;
   int m_period = 0;
   bit m_err    = 1'b0;
   int m_count  = 0;
   bit m_to     = 1'b0;
   bit m_ov     = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model(input bit r, input bit s, input bit rd);
      bit rise;
      bit accept;
      bit produce;
      int p;
      m_cyc++;
      if (r) begin
         m_prev = 0; m_meas = 0; m_valid = 0; m_period = 0; m_err = 0;
         m_count = 0; m_to = 0; m_ov = 0;
         return;
      end
      rise    = s && !m_prev;
      m_prev  = s;
      accept  = m_valid && rd;
      produce = 1'b0;
      p       = 0;
      if (rise) begin
         m_count = (m_count + 1) % (1 << CB);
         if (m_meas) begin
            produce = 1'b1;
            p       = m_cyc - m_last;
         end
         m_meas = 1'b1;
         m_last = m_cyc;
      end else if (m_meas && (m_cyc - m_last) == MAXC) begin
         m_to   = 1'b1;
         m_meas = 1'b0;
      end
      if (produce) begin
         if (!m_valid || rd) begin
            m_valid  = 1'b1;
            m_period = p;
            m_err    = (p < int'(EXP - TOL)) || (p > int'(EXP + TOL));
         end else begin
            m_ov = 1'b1;
         end
      end else if (accept) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic check_all();
      chk("valid",    32'(out_valid),  32'(m_valid));
      chk("period",   32'(out_period), 32'(m_period));
      chk("err",      32'(out_err),    32'(m_err));
      chk("count",    32'(peak_count), 32'(m_count));
      chk("timeout",  32'(timeout),    32'(m_to));
      chk("overflow", 32'(overflow),   32'(m_ov));
   endtask

   task automatic cyc(input bit r, input bit s, input bit rd);
      rst       = r;
      sig_in    = s;
      out_ready = rd;
      @(posedge clk);
      model(r, s, rd);
      #1;
      check_all();
   endtask

   task automatic pulse(input int width, input int spacing, input bit rd);
      for (int i = 0; i < spacing; i++) cyc(1'b0, i < width, rd);
   endtask

   initial begin
      rst       = 1'b1;
      sig_in    = 1'b0;
      out_ready = 1'b1;

      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      chk("rst_valid",   32'(out_valid),  32'd0);
      chk("rst_count",   32'(peak_count), 32'd0);
      chk("rst_timeout", 32'(timeout),    32'd0);

      // Nominal spacing: first pulse gives no result, later ones period 10.
      for (int i = 0; i < 4; i++) pulse(2, 10, 1'b1);
      chk("nominal_count", 32'(peak_count), 32'd4);

      // Off-window then in-window periods.
      pulse(2, 12, 1'b1);
      pulse(2, 9, 1'b1);
      pulse(2, 10, 1'b1);

      // Accept coincides with a new result.
      pulse(2, 10, 1'b0);
      pulse(2, 10, 1'b1);
      chk("coincide_ovf", 32'(overflow), 32'd0);

      // Busy output drops results.
      for (int i = 0; i < 3; i++) pulse(2, 10, 1'b0);
      chk("ovf_sticky", 32'(overflow),   32'd1);
      chk("ovf_hold",   32'(out_period), 32'd10);
      chk("ovf_valid",  32'(out_valid),  32'd1);
      cyc(1'b0, 1'b0, 1'b1);
      chk("ovf_drain",  32'(out_valid),  32'd0);

      // Lost peak, then restart.
      pulse(1, 70, 1'b1);
      chk("timeout_set", 32'(timeout), 32'd1);
      pulse(2, 10, 1'b1);
      pulse(2, 10, 1'b1);
      chk("restart_period", 32'(out_period), 32'd10);

      // Reset mid-measurement with a result pending.
      pulse(2, 10, 1'b0);
      pulse(2, 10, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      chk("midrst_valid",    32'(out_valid),  32'd0);
      chk("midrst_period",   32'(out_period), 32'd0);
      chk("midrst_overflow", 32'(overflow),   32'd0);
      pulse(2, 10, 1'b1);

      // Randomized traffic with varying peak density, including timeouts and resets.
      for (int i = 0; i < 3000; i++) begin
         int  k;
         bit  s;
         bit  rd;
         bit  r;
         k  = ((i / 500) % 3 == 0) ? 6 : (((i / 500) % 3 == 1) ? 12 : 80);
         s  = ($urandom_range(0, k - 1) == 0);
         rd = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 499) == 0);
         cyc(r, s, rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_peak_monitor.md
Name: load_store_peak_monitor

Overview:
- Downstream consumer of the load/store ramp stage's peak strobe `sig`, which is high while the volume counter sits at its ceiling.
- Detects each peak's rising edge, counts peaks and measures the cycle period between consecutive peaks.
- Checks each period against an expected window and hands the result to the status/log stage over a valid/ready interface.
- Flags lost peaks (timeout) and dropped results (overflow) with sticky bits.

Parameters:
- PBITS, 16, width of period counter and `out_period`.
- EXP_PERIOD, 40002, expected rise-to-rise period in cycles (2*N+2 for N=20000).
- TOL, 4, allowed deviation: period is good iff EXP_PERIOD-TOL <= period <= EXP_PERIOD+TOL.
- CNTBITS, 16, width of `peak_count`.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- sig_in  input  1  peak strobe from the load/store stage; same clock domain, no synchroniser.
- out_valid  output  1  period result available.
- out_ready  input  1  consumer accepts result when out_valid && out_ready.
- out_period  output  PBITS  measured rise-to-rise period in cycles.
- out_err  output  1  measured period outside the tolerance window.
- peak_count  output  CNTBITS  number of sig_in rising edges since reset; wraps.
- timeout  output  1  sticky: period counter saturated with no peak.
- overflow  output  1  sticky: a result was dropped because the output was busy.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, sig_d=0, cnt=0, state=IDLE. Reset wins over every other event, including mid-measurement and mid-handshake.
- Edge detect: sig_d <= sig_in each cycle; rise = sig_in & ~sig_d. A level held high for several cycles produces exactly one rise.
- On every rise: peak_count <= peak_count+1, wrapping at 2^CNTBITS.
- State IDLE: on rise, go to MEAS with cnt <= 1. No result is produced for the first peak.
- State MEAS, no rise: cnt <= cnt+1.
  - If cnt == all-ones, set timeout, go to IDLE and set cnt <= 0. The next rise restarts measurement without producing a result.
- State MEAS, rise: the measurement is P = cnt (cycles since previous rise). Produce a result, set cnt <= 1, stay in MEAS.
  - Example: rises at cycles t and t+10 give P=10.
- Producing a result:
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle (accept and load coincide): load out_period <= P and out_err <= (P < EXP_PERIOD-TOL) || (P > EXP_PERIOD+TOL), with out_valid <= 1.
  - Otherwise, keep the old result unchanged and set overflow.
- Handshake:
  - out_valid, out_period and out_err are stable while out_valid && !out_ready.
  - On accept with no new result that cycle, out_valid <= 0.
- Latency: the result is visible one cycle after the clock edge where the rise is sampled.
- Window arithmetic: computed at PBITS+1 bits. EXP_PERIOD-TOL clamps at 0.
- timeout and overflow clear only on rst.

Test Plan:
- Params PBITS=6, EXP_PERIOD=10, TOL=1. Pulse sig_in high for 2 cycles every 10 cycles, out_ready=1 -> first pulse gives no result; each later pulse gives a 1-cycle out_valid with out_period=10, out_err=0; peak_count increments once per pulse.
- Pulse spacing 12, then 9 -> out_period=12 with out_err=1, then out_period=9 with out_err=0.
- out_ready=0 with two result-producing pulses 10 cycles apart -> first result held stable, overflow=1, out_period stays 10 after the second pulse; raising out_ready then clears out_valid one cycle later.
- Accept and new result in the same cycle -> out_valid stays 1, out_period takes the new value, overflow stays 0.
- One pulse, then sig_in=0 for 70 cycles -> timeout=1 after cnt reaches 63 and the block returns to IDLE; the next two pulses 10 apart yield exactly one result, out_period=10.
- Assert rst for 1 cycle mid-measurement with out_valid=1 -> all outputs 0 next cycle; the next pulse produces no result.
